// File: rtl/wb_result_stage.sv
// wb_result_stage: registered writeback stage with five-source result select, load extraction and retire counter
//
// Ports:
//   clk, reset                      rising-edge clock, synchronous active-high reset
//   in_valid / in_ready             MEM-stage handshake (in_ready depends on state only)
//   reg_write_mode                  0/3 ALU, 1 load, 2 PC+4, 4 imm, 5 CSR, 6/7 illegal
//   reg_write, rd, funct3, addr_lo  write intent, destination, load size/sign, load byte offset
//   ALU_result, PC_plus_4, imm,
//   csr_rdata, read_data            candidate results and raw memory word
//   mem_rvalid                      read_data valid this cycle
//   rf_we, rf_rd, rf_wdata          registered register-file write port
//   misaligned, illegal_mode        one-cycle fault pulses on retire
//   instret                         retired-instruction counter (wraps)
module wb_result_stage #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 64
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [2:0]                    reg_write_mode,
    input  logic                          reg_write,
    input  logic [4:0]                    rd,
    input  logic [2:0]                    funct3,
    input  logic [$clog2(XLEN/8)-1:0]     addr_lo,
    input  logic [XLEN-1:0]               ALU_result,
    input  logic [XLEN-1:0]               PC_plus_4,
    input  logic [XLEN-1:0]               imm,
    input  logic [XLEN-1:0]               csr_rdata,
    input  logic [XLEN-1:0]               read_data,
    input  logic                          mem_rvalid,
    output logic                          rf_we,
    output logic [4:0]                    rf_rd,
    output logic [XLEN-1:0]               rf_wdata,
    output logic                          misaligned,
    output logic                          illegal_mode,
    output logic [CNT_W-1:0]              instret
);
    localparam int AW = $clog2(XLEN/8);

    typedef enum logic {IDLE, WAIT_MEM} state_t;
    state_t state, state_nx;

    logic [4:0]      l_rd;
    logic            l_rw;
    logic [2:0]      l_f3;
    logic [AW-1:0]   l_al;
    logic            waiting, is_load, accept, retire;
    logic [2:0]      s_mode, s_f3, f3e;
    logic [4:0]      s_rd;
    logic            s_rw, uns, mis, ill, fault;
    logic [1:0]      sz;
    logic [AW-1:0]   s_al, lane;
    logic [XLEN-1:0] sh, ld_data, result;

    assign waiting  = state == WAIT_MEM;
    assign in_ready = state == IDLE;
    assign is_load  = reg_write_mode == 3'd1;
    assign accept   = in_valid && state == IDLE;

    // While waiting, the retiring instruction is the latched load, not the live inputs
    assign s_mode = waiting ? 3'd1 : reg_write_mode;
    assign s_f3   = waiting ? l_f3 : funct3;
    assign s_al   = waiting ? l_al : addr_lo;
    assign s_rd   = waiting ? l_rd : rd;
    assign s_rw   = waiting ? l_rw : reg_write;

    // Codes without a native meaning at this XLEN collapse to LW
    assign f3e  = (s_f3 == 3'b111 || (XLEN == 32 && (s_f3 == 3'b011 || s_f3 == 3'b110))) ? 3'b010 : s_f3;
    assign sz   = f3e[1:0];
    assign uns  = f3e[2];
    assign lane = sz == 2'd0 ? s_al : sz == 2'd1 ? (s_al & ~AW'(1)) : sz == 2'd2 ? (s_al & ~AW'(3)) : '0;
    assign sh   = read_data >> {lane, 3'b000};

    assign ld_data = sz == 2'd0 ? (uns ? XLEN'(sh[7:0])  : XLEN'($signed(sh[7:0]))) :
                     sz == 2'd1 ? (uns ? XLEN'(sh[15:0]) : XLEN'($signed(sh[15:0]))) :
                     sz == 2'd2 ? (uns ? XLEN'(sh[31:0]) : XLEN'($signed(sh[31:0]))) : read_data;

    assign mis   = s_mode == 3'd1 && (sz == 2'd1 ? s_al[0] : sz == 2'd2 ? s_al[1:0] != 2'd0 :
                                      sz == 2'd3 ? s_al != '0 : 1'b0);
    assign ill   = s_mode[2] && s_mode[1];
    assign fault = mis || ill;

    assign result = (s_mode == 3'd0 || s_mode == 3'd3) ? ALU_result :
                    s_mode == 3'd1 ? ld_data :
                    s_mode == 3'd2 ? PC_plus_4 :
                    s_mode == 3'd4 ? imm :
                    s_mode == 3'd5 ? csr_rdata : '0;

    always_comb begin
        state_nx = state;
        retire   = 1'b0;
        if (waiting) begin
            retire   = mem_rvalid;
            state_nx = mem_rvalid ? IDLE : WAIT_MEM;
        end else if (accept) begin
            retire   = !is_load || mem_rvalid;
            state_nx = (is_load && !mem_rvalid) ? WAIT_MEM : IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            rf_we        <= 1'b0;
            rf_rd        <= '0;
            rf_wdata     <= '0;
            misaligned   <= 1'b0;
            illegal_mode <= 1'b0;
            instret      <= '0;
        end else begin
            state        <= state_nx;
            rf_we        <= retire && s_rw && s_rd != 5'd0 && !fault;
            misaligned   <= retire && mis;
            illegal_mode <= retire && ill;
            if (retire) begin
                rf_rd    <= s_rd;
                rf_wdata <= fault ? '0 : result;
                instret  <= instret + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept && is_load && !mem_rvalid) begin
            l_rd <= rd;
            l_rw <= reg_write;
            l_f3 <= funct3;
            l_al <= addr_lo;
        end
    end
endmodule

// File: doc/wb_result_stage.md
# wb_result_stage

Registered, parametrised writeback stage for the RV32I/RV64I core. It generalises the combinational result select to five sources: ALU, load data, PC+4, immediate, and CSR read. Load data is byte/half/word aligned and sign- or zero-extended here. The stage waits on a variable-latency memory read with a valid/ready handshake, then drives the register-file write port one cycle later. It sits between the MEM stage and the register file and also counts retired instructions.

## Interface
- XLEN, 32, datapath width; legal values are 32 or 64.
- CNT_W, 64, width of the retire counter.

- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  MEM stage presents an instruction
- in_ready  out  1  stage can accept this cycle
- reg_write_mode  in  3  0 ALU, 1 load, 2 PC+4, 3 ALU, 4 imm, 5 CSR, 6/7 illegal
- reg_write  in  1  instruction writes rd
- rd  in  5  destination register
- funct3  in  3  load size/sign (RISC-V encoding)
- addr_lo  in  log2(XLEN/8)  low bits of the load address
- ALU_result, PC_plus_4, imm, csr_rdata  in  XLEN  candidate results
- read_data  in  XLEN  raw memory word
- mem_rvalid  in  1  read_data valid this cycle
- rf_we  out  1  register-file write enable
- rf_rd  out  5  write address
- rf_wdata  out  XLEN  write data
- misaligned  out  1  one-cycle pulse: misaligned load retired
- illegal_mode  out  1  one-cycle pulse: mode 6/7 retired
- instret  out  CNT_W  retired-instruction count

## Operation
- States:
  - IDLE: in_ready=1.
  - WAIT_MEM: in_ready=0.
- Accept: in_valid && in_ready.
  - Non-load accept: compute the result, register all outputs, stay in IDLE.
  - Load accept with mem_rvalid=1: same as a non-load.
  - Load accept with mem_rvalid=0: latch rd, reg_write, funct3, addr_lo; go to WAIT_MEM.
- WAIT_MEM:
  - Each cycle with mem_rvalid=1: extract from read_data, register the outputs, return to IDLE.
  - in_valid is ignored while waiting.
- Load extraction (byte lane = addr_lo):
  - 000 LB: sign-extend byte[addr_lo].
  - 100 LBU: zero-extend byte[addr_lo].
  - 001 LH: sign-extend half[addr_lo>>1].
  - 101 LHU: zero-extend half[addr_lo>>1].
  - 010 LW: sign-extend word[addr_lo>>2].
  - 110 LWU: zero-extend word[addr_lo>>2].
  - 011 LD: full XLEN.
  - When XLEN=32, codes 011/110 and 111 are treated as LW.
- Misaligned: LH/LHU with addr_lo[0]=1, LW/LWU with addr_lo[1:0]≠0, or LD with addr_lo≠0.
  - rf_we=0, rf_wdata=0, misaligned pulses.
- Illegal mode (6/7): rf_we=0, rf_wdata=0, illegal_mode pulses.
- Write enable: rf_we = reg_write && rd≠0 && no fault.
  - rf_rd always carries rd.
  - rf_wdata carries the result even when rd=0.
- instret increments by 1 on every retire, including faults and rd=0. It wraps modulo 2^CNT_W.

## Timing
- Reset (synchronous): state=IDLE, rf_we=0, rf_rd=0, rf_wdata=0, misaligned=0, illegal_mode=0, instret=0.
  - in_ready=1 in the cycle after reset deasserts.
- Latency:
  - Non-load: rf_we valid in cycle N+1 after the accept in cycle N.
  - Load: valid in cycle M+1 after mem_rvalid in cycle M.
- rf_we, misaligned and illegal_mode are single-cycle pulses per retire.
- rf_rd and rf_wdata hold their last value when rf_we=0.
- Back-to-back: one instruction per cycle in IDLE with no bubbles.
- in_ready is combinational from state only; it has no path from in_valid.
- Reset in WAIT_MEM: abandon the load, nothing retires, instret is unchanged by that load.
- mem_rvalid in IDLE without a load accept is ignored.

## Test plan
- Reset: assert reset 2 cycles mid-WAIT_MEM -> all outputs 0, state IDLE, in_ready=1, instret=0.
- Source select:
  - Mode 0: ALU_result=0x12345678, rd=5, reg_write=1 -> next cycle rf_we=1, rf_rd=5, rf_wdata=0x12345678.
  - Mode 2: PC_plus_4=0x104 -> 0x104.
  - Mode 4: imm=0xABCDE000 -> 0xABCDE000.
  - Mode 5: csr_rdata=0x1800 -> 0x1800.
- Load extraction, XLEN=32, read_data=0x80FF7F01:
  - LB addr_lo=2 -> 0xFFFFFFFF.
  - LBU addr_lo=3 -> 0x00000080.
  - LH addr_lo=2 -> 0xFFFF80FF.
  - LHU addr_lo=0 -> 0x00007F01.
  - LW addr_lo=0 -> 0x80FF7F01.
- Wait state: load accepted with mem_rvalid=0, data arrives 3 cycles later -> in_ready=0 for 3 cycles, rf_we=1 one cycle after mem_rvalid, instret+1.
- Faults:
  - LW addr_lo=2 -> rf_we=0, misaligned=1 for one cycle.
  - Mode 7 -> rf_we=0, illegal_mode=1.
  - rd=0 mode 0 -> rf_we=0.
  - Each case still gives instret+1.
- XLEN=64, CNT_W=4:
  - LWU addr_lo=4, read_data=0xF0000000_00000000 -> 0x00000000_F0000000.
  - 16 retires -> instret wraps to 0.
